// File: rtl/nco_phase_glide.sv
// NCO phase accumulator with valid/ready increment loading and exponential glide.
// Define NCO_DITHER_EN to add LFSR dither below the 16-bit output slice.
module nco_phase_glide #(
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned GLIDE_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [PHASE_W-1:0] i_inc,
  input  logic               i_inc_valid,
  output logic               o_inc_ready,
  input  logic [GLIDE_W-1:0] i_glide,
  input  logic               i_sync,
  output logic [15:0]        o_saw,
  output logic               o_wrap,
  output logic               o_gliding
);

  typedef enum logic [0:0] {StSteady, StGlide} state_e;

  state_e               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [PHASE_W-1:0]   cur_inc_q, cur_inc_d;
  logic [PHASE_W-1:0]   target_q, target_d;
  logic [PHASE_W-1:0]   pend_val_q, pend_val_d;
  logic                 pending_q, pending_d;
  logic                 wrap_q, wrap_d;

  logic                 accept;
  logic [PHASE_W-1:0]   eff;
  logic [PHASE_W:0]     sum;
  logic signed [PHASE_W:0] delta, step_shr, step;
  logic [PHASE_W-1:0]   glide_inc;

  always_comb begin
    accept    = i_inc_valid && !pending_q;
    eff       = pending_q ? pend_val_q : target_q;
    sum       = {1'b0, phase_q} + {1'b0, cur_inc_q};
    delta     = $signed({1'b0, eff}) - $signed({1'b0, cur_inc_q});
    step_shr  = delta >>> i_glide;
    // A shift that rounds to zero still moves one LSB toward the target.
    if (step_shr == '0) begin
      step = delta[PHASE_W] ? '1 : {{PHASE_W{1'b0}}, 1'b1};
    end else begin
      step = step_shr;
    end
    glide_inc = cur_inc_q + step[PHASE_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cur_inc_d  = cur_inc_q;
    target_d   = target_q;
    pend_val_d = pend_val_q;
    pending_d  = pending_q;
    wrap_d     = 1'b0;

    if (accept) begin
      pend_val_d = i_inc;
      pending_d  = 1'b1;
    end

    if (i_en) begin
      if (pending_q) begin
        pending_d = 1'b0;
      end
      target_d = eff;

      if (i_sync) begin
        phase_d = '0;
        wrap_d  = 1'b0;
      end else begin
        {wrap_d, phase_d} = sum;
      end

      case (state_q)
        StSteady: begin
          if (eff != cur_inc_q) begin
            if (i_glide == '0) begin
              cur_inc_d = eff;
            end else begin
              cur_inc_d = glide_inc;
              state_d   = (glide_inc == eff) ? StSteady : StGlide;
            end
          end
        end
        StGlide: begin
          if (i_glide == '0 || eff == cur_inc_q) begin
            cur_inc_d = eff;
            state_d   = StSteady;
          end else begin
            cur_inc_d = glide_inc;
            if (glide_inc == eff) begin
              state_d = StSteady;
            end
          end
        end
        default: state_d = StSteady;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StSteady;
      phase_q    <= '0;
      cur_inc_q  <= '0;
      target_q   <= '0;
      pend_val_q <= '0;
      pending_q  <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cur_inc_q  <= cur_inc_d;
      target_q   <= target_d;
      pend_val_q <= pend_val_d;
      pending_q  <= pending_d;
      wrap_q     <= wrap_d;
    end
  end

  assign o_inc_ready = !pending_q;
  assign o_wrap      = wrap_q;
  assign o_gliding   = (state_q == StGlide);

`ifdef NCO_DITHER_EN
  logic [15:0]        lfsr_q;
  logic [15:0]        saw_q;
  logic               lfsr_fb;
  logic [PHASE_W-1:0] dith;
  logic [PHASE_W-1:0] dsum;

  always_comb begin
    lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    dith    = '0;
    // Dither only occupies bits below the output slice.
    for (int i = 0; i < 8; i++) begin
      if (i < int'(PHASE_W) - 16) begin
        dith[i] = lfsr_q[i];
      end
    end
    dsum = phase_d + dith;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_q <= 16'hACE1;
      saw_q  <= '0;
    end else if (i_en) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
      saw_q  <= dsum[PHASE_W-1 -: 16];
    end
  end

  assign o_saw = saw_q;
`else
  assign o_saw = phase_q[PHASE_W-1 -: 16];
`endif

endmodule

// File: tb/tb_nco_phase_glide.sv
// Directed self-checking bench for nco_phase_glide (default build, no dither).
module tb_nco_phase_glide;
  localparam int unsigned PW = 24;
  localparam int unsigned GW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b1;
  logic          i_en = 1'b0;
  logic [PW-1:0] i_inc = '0;
  logic          i_inc_valid = 1'b0;
  logic          o_inc_ready;
  logic [GW-1:0] i_glide = '0;
  logic          i_sync = 1'b0;
  logic [15:0]   o_saw;
  logic          o_wrap;
  logic          o_gliding;

  int errors = 0;
  int checks = 0;
  int glide_exp [20] = '{64, 112, 148, 175, 195, 210, 221, 229, 235, 240,
                         244, 247, 249, 250, 251, 252, 253, 254, 255, 256};

  nco_phase_glide #(.PHASE_W(PW), .GLIDE_W(GW)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (i_en),
    .i_inc       (i_inc),
    .i_inc_valid (i_inc_valid),
    .o_inc_ready (o_inc_ready),
    .i_glide     (i_glide),
    .i_sync      (i_sync),
    .o_saw       (o_saw),
    .o_wrap      (o_wrap),
    .o_gliding   (o_gliding)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive inputs on the falling edge, return 1 time unit after the rising edge.
  task automatic cyc(input logic en, input logic sync, input logic valid,
                     input logic [PW-1:0] inc, input logic [GW-1:0] glide);
    @(negedge i_clk);
    i_en        = en;
    i_sync      = sync;
    i_inc_valid = valid;
    i_inc       = inc;
    i_glide     = glide;
    @(posedge i_clk);
    #1;
  endtask

  task automatic tick(input logic [GW-1:0] glide);
    cyc(1'b1, 1'b0, 1'b0, '0, glide);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_saw"}, 32'(o_saw), 32'h0);
    chk({tag, "_wrap"}, 32'(o_wrap), 32'h0);
    chk({tag, "_gliding"}, 32'(o_gliding), 32'h0);
    chk({tag, "_ready"}, 32'(o_inc_ready), 32'h1);
  endtask

  task automatic do_reset(input string tag);
    @(negedge i_clk);
    i_en = 1'b0; i_sync = 1'b0; i_inc_valid = 1'b0;
    i_rst_n = 1'b0;
    #1;
    chk_reset_outputs(tag);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    #1 i_rst_n = 1'b0;
    #2 chk_reset_outputs("por");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Steady tone: first tick transfers the target, later ticks add.
    cyc(1'b0, 1'b0, 1'b1, 24'h010000, 4'd0);
    chk("tone_accept_ready", 32'(o_inc_ready), 32'h0);
    tick(4'd0);
    chk("tone_t1_saw", 32'(o_saw), 32'h0000);
    chk("tone_t1_ready", 32'(o_inc_ready), 32'h1);
    chk("tone_t1_gliding", 32'(o_gliding), 32'h0);
    tick(4'd0);
    chk("tone_t2_saw", 32'(o_saw), 32'h0100);
    tick(4'd0);
    chk("tone_t3_saw", 32'(o_saw), 32'h0200);
    for (int n = 4; n <= 257; n++) begin
      tick(4'd0);
      chk("tone_loop_saw", 32'(o_saw), 32'(((n - 1) * 256) & 16'hFFFF));
      chk("tone_loop_wrap", 32'(o_wrap), (n == 257) ? 32'h1 : 32'h0);
    end
    cyc(1'b0, 1'b0, 1'b0, '0, 4'd0);
    chk("tone_idle_wrap", 32'(o_wrap), 32'h0);
    chk("tone_idle_saw", 32'(o_saw), 32'h0000);

    // Hard sync mid-ramp.
    for (int n = 0; n < 127; n++) tick(4'd0);
    chk("sync_pre_saw", 32'(o_saw), 32'h7F00);
    cyc(1'b1, 1'b1, 1'b0, '0, 4'd0);
    chk("sync_saw", 32'(o_saw), 32'h0000);
    chk("sync_wrap", 32'(o_wrap), 32'h0);
    tick(4'd0);
    chk("sync_next_saw", 32'(o_saw), 32'h0100);

    // Handshake backpressure without ticks.
    cyc(1'b0, 1'b0, 1'b1, 24'h020000, 4'd0);
    chk("hs_acc1_ready", 32'(o_inc_ready), 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 24'h030000, 4'd0);
    chk("hs_hold_ready", 32'(o_inc_ready), 32'h0);
    cyc(1'b1, 1'b0, 1'b1, 24'h030000, 4'd0);
    chk("hs_h1_saw", 32'(o_saw), 32'h0200);
    chk("hs_h1_ready", 32'(o_inc_ready), 32'h1);
    cyc(1'b0, 1'b0, 1'b1, 24'h030000, 4'd0);
    chk("hs_acc2_ready", 32'(o_inc_ready), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, '0, 4'd0);
    chk("hs_acc2_hold", 32'(o_inc_ready), 32'h0);
    tick(4'd0);
    chk("hs_h2_saw", 32'(o_saw), 32'h0400);
    chk("hs_h2_ready", 32'(o_inc_ready), 32'h1);
    tick(4'd0);
    chk("hs_h3_saw", 32'(o_saw), 32'h0700);

    // Asynchronous reset in the middle of a glide.
    cyc(1'b0, 1'b0, 1'b1, 24'h100000, 4'd1);
    tick(4'd1);
    chk("rg_saw", 32'(o_saw), 32'h0A00);
    chk("rg_gliding", 32'(o_gliding), 32'h1);
    cyc(1'b0, 1'b0, 1'b1, 24'h000005, 4'd1);
    chk("rg_ready", 32'(o_inc_ready), 32'h0);
    #2;
    i_en = 1'b1;
    i_rst_n = 1'b0;
    #1;
    chk_reset_outputs("rg_async");
    @(posedge i_clk);
    #1;
    chk("rg_hold_wrap", 32'(o_wrap), 32'h0);
    chk("rg_hold_saw", 32'(o_saw), 32'h0);
    @(negedge i_clk);
    i_en = 1'b0;
    i_inc_valid = 1'b0;
    i_rst_n = 1'b1;

    // Exponential glide 0 -> 256 with shift 2.
    cyc(1'b0, 1'b0, 1'b1, 24'h000100, 4'd2);
    for (int i = 0; i < 20; i++) begin
      tick(4'd2);
      chk("glide_cur_inc", 32'(dut.cur_inc_q), 32'(glide_exp[i]));
      chk("glide_gliding", 32'(o_gliding), (i < 19) ? 32'h1 : 32'h0);
    end
    tick(4'd2);
    chk("glide_settled_inc", 32'(dut.cur_inc_q), 32'd256);
    chk("glide_settled_flag", 32'(o_gliding), 32'h0);

    // Wrap boundary: phase 0xFFFF80 plus 0x100.
    do_reset("wb_reset");
    cyc(1'b0, 1'b0, 1'b1, 24'hFFFF80, 4'd0);
    tick(4'd0);
    cyc(1'b0, 1'b0, 1'b1, 24'h000100, 4'd0);
    tick(4'd0);
    chk("wb_pre_saw", 32'(o_saw), 32'hFFFF);
    chk("wb_pre_wrap", 32'(o_wrap), 32'h0);
    tick(4'd0);
    chk("wb_saw", 32'(o_saw), 32'h0000);
    chk("wb_wrap", 32'(o_wrap), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, '0, 4'd0);
    chk("wb_wrap_clear", 32'(o_wrap), 32'h0);
    chk("wb_idle_saw", 32'(o_saw), 32'h0000);
    tick(4'd0);
    chk("wb_next_saw", 32'(o_saw), 32'h0001);
    chk("wb_next_wrap", 32'(o_wrap), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
